sram_1p_arbiter: RTL and testbench

// - Shares one single-port 1RW SRAM macro (RW0 style: en/wmode/addr/wdata in, rdata 1 cycle after read)

---
 rtl/sram_1p_arbiter.sv | 133 +++++++++++++
 tb/tb_sram_1p_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1p_arbiter.sv
// Arbiter sharing one 1RW SRAM between a write and a read requester, with a 2-entry read response
// buffer. Define SRAM_ARB_INIT_EN to zero-fill addresses 0..DEPTH-1 after reset before serving requests.
module sram_1p_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 128,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                rd_inflight_q, rd_grant;
  logic [DATA_W-1:0]   fifo_q [2];
  logic                rd_ptr_q, wr_ptr_q;
  logic [1:0]          cnt_q, occ;
  logic                pop, rd_ok, starved, read_win;
`ifdef SRAM_ARB_INIT_EN
  logic [ADDR_W-1:0]   init_addr_q, init_addr_d;
`endif

  // Occupancy counts the read still inside the SRAM so the buffer can never be oversubscribed.
  assign resp_valid = (cnt_q != 2'd0);
  assign resp_data  = fifo_q[rd_ptr_q];
  assign pop        = resp_valid & resp_ready;
  assign occ        = cnt_q + {1'b0, rd_inflight_q};
  assign rd_ok      = (occ < 2'd2) | ((occ == 2'd2) & pop);
  assign starved    = (starve_q >= STARVE_W'(STARVE_MAX));
  assign read_win   = r_valid & rd_ok & ~(w_valid & starved);

  always_comb begin
    // NOTE: every combinationally driven signal gets a default first, so no path can infer a latch.
    state_d    = state_q;
    starve_d   = starve_q;
    rd_grant   = 1'b0;
    init_done  = 1'b0;
    w_ready    = 1'b0;
    r_ready    = 1'b0;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
`ifdef SRAM_ARB_INIT_EN
    init_addr_d = init_addr_q;
`endif
    case (state_q)
      S_INIT: begin
`ifdef SRAM_ARB_INIT_EN
        // The sweep is qualified by reset_n so the array sees no write while reset is held.
        sram_en     = reset_n;
        sram_wmode  = reset_n;
        sram_addr   = init_addr_q;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == ADDR_W'(DEPTH - 1)) state_d = S_RUN;
`else
        state_d = S_RUN;
`endif
      end
      S_RUN: begin
        init_done = 1'b1;
        r_ready   = read_win;
        w_ready   = ~read_win;
        if (read_win) begin
          rd_grant  = 1'b1;
          sram_en   = 1'b1;
          sram_addr = r_addr;
        end else if (w_valid) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = w_addr;
          sram_wdata = w_data;
        end
        if (w_valid & ~read_win) starve_d = '0;
        else if (w_valid & ~starved) starve_d = starve_q + 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_INIT;
      starve_q      <= '0;
      rd_inflight_q <= 1'b0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      cnt_q         <= 2'd0;
      // NOTE: the buffer is only two entries and its head drives resp_data, so it is reset like any register.
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      rd_inflight_q <= rd_grant;
      cnt_q         <= cnt_q + {1'b0, rd_inflight_q} - {1'b0, pop};
      if (rd_inflight_q) begin
        fifo_q[wr_ptr_q] <= sram_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

`ifdef SRAM_ARB_INIT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) init_addr_q <= '0;
    else          init_addr_q <= init_addr_d;
  end
`endif

endmodule

// File: tb/tb_sram_1p_arbiter.sv
// Bench for sram_1p_arbiter: behavioural SRAM plus a transaction-level reference model
// (array contents, queue of outstanding reads with issue cycle, write starvation count).
module tb_sram_1p_arbiter;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int DEPTH      = 128;
  localparam int STARVE_MAX = 4;
`ifdef SRAM_ARB_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              w_valid = 1'b0, r_valid = 1'b0, resp_ready = 1'b0;
  logic [ADDR_W-1:0] w_addr = '0, r_addr = '0;
  logic [DATA_W-1:0] w_data = '0;
  logic              w_ready, r_ready, resp_valid, init_done;
  logic [DATA_W-1:0] resp_data;
  logic              sram_en, sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;

  always #5 clock = ~clock;

  sram_1p_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .init_done(init_done),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural 1RW macro: read data registered one cycle after a read enable.
  logic [DATA_W-1:0] sram_mem [DEPTH];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) sram_mem[sram_addr] <= sram_wdata;
      else            sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Reference model state.
  typedef struct {
    logic [DATA_W-1:0] data;
    int                issued;
  } rsp_t;

  logic [DATA_W-1:0] ref_mem [DEPTH];
  rsp_t              pend[$];
  int                cyc;
  int                init_left;
  int                starve;
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    starve    = 0;
    cyc       = 0;
    init_left = INIT_EN ? DEPTH : 1;
  endtask

  // Called just after a falling edge with inputs applied; checks this cycle, advances the model, waits a cycle.
  task automatic step();
    bit   run, exp_rv, exp_pop, rd_ok, rwin, wfire;
    rsp_t r;
    #1;
    run     = (init_left == 0);
    exp_rv  = (pend.size() > 0) && (pend[0].issued + 2 <= cyc);
    exp_pop = exp_rv && resp_ready;
    rd_ok   = (pend.size() < 2) || (pend.size() == 2 && exp_pop);
    rwin    = run && r_valid && rd_ok && !(w_valid && starve >= STARVE_MAX);
    wfire   = run && !rwin && w_valid;

    check("init_done", init_done, run);
    check("r_ready", r_ready, rwin);
    check("w_ready", w_ready, run && !rwin);
    check("resp_valid", resp_valid, exp_rv);
    if (exp_rv) check("resp_data", resp_data, pend[0].data);

    if (!run && INIT_EN) begin
      check("init_en", sram_en, 1);
      check("init_wmode", sram_wmode, 1);
      check("init_addr", sram_addr, DEPTH - init_left);
      check("init_wdata", sram_wdata, 0);
      ref_mem[DEPTH - init_left] = '0;
    end else if (rwin) begin
      check("rd_en", sram_en, 1);
      check("rd_wmode", sram_wmode, 0);
      check("rd_addr", sram_addr, r_addr);
    end else if (wfire) begin
      check("wr_en", sram_en, 1);
      check("wr_wmode", sram_wmode, 1);
      check("wr_addr", sram_addr, w_addr);
      check("wr_wdata", sram_wdata, w_data);
    end else begin
      check("idle_en", sram_en, 0);
    end

    if (exp_pop) void'(pend.pop_front());
    if (rwin) begin
      r.data   = ref_mem[r_addr];
      r.issued = cyc;
      pend.push_back(r);
    end
    if (wfire) begin
      ref_mem[w_addr] = w_data;
      starve = 0;
    end else if (run && w_valid && starve < STARVE_MAX) begin
      starve++;
    end
    if (!run) init_left--;
    cyc++;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input bit wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input bit rv, input logic [ADDR_W-1:0] ra, input bit rr);
    w_valid    = wv;
    w_addr     = wa;
    w_data     = wd;
    r_valid    = rv;
    r_addr     = ra;
    resp_ready = rr;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, '0, 0, '0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_w_ready"}, w_ready, 0);
    check({tag, "_r_ready"}, r_ready, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_sram_en"}, sram_en, 0);
    check({tag, "_sram_wmode"}, sram_wmode, 0);
    check({tag, "_sram_addr"}, sram_addr, 0);
    check({tag, "_sram_wdata"}, sram_wdata, 0);
    check({tag, "_init_done"}, init_done, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v           = DATA_W'($urandom);
      sram_mem[i] <= v;
      ref_mem[i]  = v;
    end

    // Reset with requests asserted: nothing may be granted.
    w_valid = 1'b1; r_valid = 1'b1; resp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    check_reset_outputs("rst");

    // Release reset at a falling edge; the model starts counting cycles from here.
    w_valid = 1'b0; r_valid = 1'b0;
    reset_n = 1'b1;
    model_reset();
    while (init_left > 0) drive(0, '0, '0, 0, '0, 1);

    if (INIT_EN) begin
      drive(0, '0, '0, 1, 7'h55, 1);
      idle(3);
    end

    // Write then read of the same address on the next cycle.
    drive(1, 7'h10, 8'h3C, 0, '0, 1);
    drive(0, '0, '0, 1, 7'h10, 1);
    idle(3);

    // Streaming reads.
    for (int i = 0; i < 8; i++) drive(0, '0, '0, 1, ADDR_W'(i * 5), 1);
    idle(3);

    // Backpressure: two reads accepted, third stalls, write still goes, pop lets the third in.
    for (int i = 0; i < 3; i++) drive(0, '0, '0, 1, ADDR_W'(7'h20 + i), 0);
    drive(1, 7'h22, 8'hA5, 1, 7'h22, 0);
    drive(0, '0, '0, 1, 7'h22, 1);
    idle(4);

    // Starvation: both requesters held high.
    for (int i = 0; i < 12; i++) drive(1, ADDR_W'(7'h30 + i), DATA_W'(8'h80 + i), 1, ADDR_W'(7'h30 + i), 1);
    idle(3);

    // Randomized traffic over a small address window to provoke read-after-write hazards.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) < 55), ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom),
            ($urandom_range(0, 99) < 70), ADDR_W'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 65));
    end
    idle(4);

    // Reset one cycle after a read grant: the read and any buffered data are dropped.
    drive(0, '0, '0, 1, 7'h21, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    while (init_left > 0) drive(0, '0, '0, 0, '0, 1);
    idle(4);
    for (int i = 0; i < 60; i++) begin
      drive(($urandom_range(0, 99) < 50), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
            ($urandom_range(0, 99) < 70), ADDR_W'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 60));
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
